mcu_spi_frame_tx: RTL and testbench
===================================

// Module: mcu_spi_frame_tx
// PURPOSE
//  Parametrised FPGA->MCU SPI slave (Mode 0) streaming raw BNO085 data for NUM_SENSORS sensors.
//  Latches sensor samples on valid pulses, snapshots them into a frame at chip-select fall,
//  and shifts out a header/sequence/data/flags/CRC-8 frame. Fully synchronous: SCK/CS_N/SDI
//  are oversampled in the clk domain. Sits between the BNO085 controllers and the MCU SPI pins.
// PARAMETERS
//  NUM_SENSORS  2      sensors per frame, 1..4
//  HEADER_BYTE  8'hAA  frame byte 0
//  SYNC_STAGES  2      synchroniser depth on sck/cs_n/sdi, >=2
//  CRC_EN       1      1: last byte = CRC-8; 0: last byte = 8'h00
// PORTS
//  clk          in   1          system clock; must be >= 8x SCK
//  rst          in   1          synchronous, active-high reset
//  sck          in   1          SPI clock from MCU (async)
//  cs_n         in   1          SPI chip select from MCU, active low (async)
//  sdi          in   1          MOSI; synchronised, unused (reserved)
//  sdo          out  1          MISO, MSB first
//  done         out  1          fresh data pending for MCU
//  overrun      out  1          sample overwritten before being framed (sticky until frame start)
//  quat_valid   in   N          per-sensor 1-cycle quaternion strobe
//  quat_data    in   64*N       sensor i at [64i+:64] = {w,x,y,z}, signed 16b each
//  gyro_valid   in   N          per-sensor 1-cycle gyro strobe
//  gyro_data    in   48*N       sensor i at [48i+:48] = {x,y,z}, signed 16b each
// BEHAVIOUR
//  Reset: sdo=0, done=0, overrun=0, seq=0, shadow/frame regs=0, fresh flags=0, FSM=IDLE.
//  Frame (FRAME_BYTES = 4+14*N): [0]=HEADER_BYTE, [1]=seq, then per sensor i ascending:
//   w,x,y,z,gx,gy,gz as MSB,LSB; [FRAME_BYTES-2]=flags{bit2i=quat fresh i, bit2i+1=gyro fresh i};
//   [FRAME_BYTES-1]=CRC-8 (poly 0x07, init 0x00, no reflect) over bytes 0..FRAME_BYTES-2.
//  Capture: quat_valid[i] loads quat shadow i, sets qfresh[i]; same for gyro; done <= 1 next cycle.
//   Strobe while fresh bit already set -> overrun <= 1 (data still overwritten).
//  Edges: detected on synchronised signals (SYNC_STAGES cycles latency); cs fall/rise, sck rise/fall.
//  FSM IDLE: sdo=0. cs fall -> snapshot shadows+flags into frame buffer, clear fresh flags,
//   done<=0, overrun<=0, seq+=1 after snapshot (frame carries pre-increment value), bit_idx=0,
//   drive sdo=frame bit 0 (MSB byte 0) -> SHIFT.
//  SHIFT: sck fall -> bit_idx+1, sdo = next bit; CRC updated with each bit as it leaves (bit-serial).
//   During CRC byte sdo = crc[7-k] (or 0 if CRC_EN=0). sck rise: no action (MCU samples).
//   After bit 8*FRAME_BYTES-1 shifted, sck fall -> TAIL.
//  TAIL: sdo=0 for any extra clocks. cs rise in SHIFT or TAIL -> IDLE.
//  Abort: cs rise mid-frame -> IDLE; frame counts as consumed (flags already cleared, seq advanced).
//  Strobe coincident with snapshot: new sample goes to shadow after snapshot, fresh set, done=1.
//  sck edges in IDLE ignored. seq wraps 255->0. rst mid-frame -> full reset, sdo=0 same cycle+1.
// STRUCTURE
//  Package mcu_spi_pkg: HEADER_BYTE default, CRC8_POLY=8'h07, BYTES_PER_SENSOR=14,
//   frame_bytes(n) function, typedef enum {IDLE,SHIFT,TAIL} spi_tx_state_t.
//  Sub-module crc8_serial (clk, rst, clr, en, bit_in, crc[7:0]); synchroniser inline.
// TESTING
//  N=2, no strobes, cs fall + 288 clocks: frame AA,00,00x28,00,CRC=crc8(bytes0..30); done stays 0.
//  Strobe quat0={1000,-1,2,3}, gyro1={5,6,7}: done=1; frame bytes 2..9 = 03 E8 FF FF 00 02 00 03,
//   flags=0x09, then done=0, second frame flags=0x00, seq=01.
//  Two quat_valid[0] before read -> overrun=1; cleared at next cs fall; frame holds 2nd sample.
//  cs rise after 13 bits -> IDLE, sdo=0; next frame seq incremented, flags=0x00.
//  Strobe on snapshot cycle -> current frame excludes it, done=1 after, next frame flags set.
//  CRC_EN=0 -> last byte 00; 300 clocks sent -> bits beyond frame all 0.

Source files
------------

// File: rtl/mcu_spi_frame_tx_pkg.sv
// Shared constants, frame sizing helper and FSM state type for the MCU SPI frame transmitter.
package mcu_spi_pkg;

    localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hAA;
    localparam logic [7:0] CRC8_POLY           = 8'h07;
    localparam int         BYTES_PER_SENSOR    = 14;

    // header + seq + sensor payload + flags + crc
    function automatic int frame_bytes(input int n);
        return 4 + BYTES_PER_SENSOR * n;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TAIL  = 2'd2
    } spi_tx_state_t;

endpackage

// File: rtl/mcu_spi_frame_tx_crc8_serial.sv
// Bit-serial CRC-8 (MSB first, init 0, no reflection), one message bit per enabled cycle.
module crc8_serial
    import mcu_spi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic fb;

    assign fb = crc[7] ^ bit_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
        end
    end

endmodule

// File: rtl/mcu_spi_frame_tx.sv
// SPI Mode 0 slave that snapshots latched sensor samples at chip-select fall and
// streams header/seq/data/flags/CRC-8 to the MCU; SPI pins are oversampled in the clk domain.
//
// state | meaning
// IDLE  | waiting for cs fall, sdo held low
// SHIFT | frame bits on sdo, advance on each sck fall
// TAIL  | frame fully sent, sdo low until cs rise
module mcu_spi_frame_tx
    import mcu_spi_pkg::*;
#(
    parameter int         NUM_SENSORS = 2,
    parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEFAULT,
    parameter int         SYNC_STAGES = 2,
    parameter bit         CRC_EN      = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sck,
    input  logic                      cs_n,
    input  logic                      sdi,
    output logic                      sdo,
    output logic                      done,
    output logic                      overrun,
    input  logic [NUM_SENSORS-1:0]    quat_valid,
    input  logic [64*NUM_SENSORS-1:0] quat_data,
    input  logic [NUM_SENSORS-1:0]    gyro_valid,
    input  logic [48*NUM_SENSORS-1:0] gyro_data
);

    localparam int FRAME_BYTES = frame_bytes(NUM_SENSORS);
    localparam int TOTAL_BITS  = 8 * FRAME_BYTES;
    localparam int BODY_BITS   = TOTAL_BITS - 8;
    localparam int SENS_BITS   = 8 * BYTES_PER_SENSOR;
    localparam int IDX_W       = $clog2(TOTAL_BITS);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_BITS - 1);
    localparam logic [IDX_W-1:0] BODY_END = IDX_W'(BODY_BITS);

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic                   sck_q;
    logic                   cs_q;
    logic                   sck_fall;
    logic                   cs_fall;
    logic                   cs_rise;
    logic                   sdi_unused;

    spi_tx_state_t state;
    spi_tx_state_t state_nxt;
    logic          snap;
    logic          shift_en;

    logic [64*NUM_SENSORS-1:0] quat_sh;
    logic [48*NUM_SENSORS-1:0] gyro_sh;
    logic [NUM_SENSORS-1:0]    qfresh;
    logic [NUM_SENSORS-1:0]    gfresh;
    logic [7:0]                seq;
    logic [7:0]                flags;

    logic [BODY_BITS-1:0] frame_next;
    logic [BODY_BITS-1:0] frame_sr;
    logic [IDX_W-1:0]     bit_idx;
    logic                 in_body;
    logic [7:0]           crc;

    // cs_n resets high so a held-low chip select after reset still produces a clean fall
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync <= '0;
            cs_sync  <= '1;
            sdi_sync <= '0;
            sck_q    <= 1'b0;
            cs_q     <= 1'b1;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            sck_q    <= sck_sync[SYNC_STAGES-1];
            cs_q     <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sck_fall   = sck_q & ~sck_sync[SYNC_STAGES-1];
    assign cs_fall    = cs_q & ~cs_sync[SYNC_STAGES-1];
    assign cs_rise    = ~cs_q & cs_sync[SYNC_STAGES-1];
    assign sdi_unused = sdi_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        snap      = 1'b0;
        shift_en  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cs_fall) begin
                    snap      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_nxt = IDLE;
                end else if (sck_fall) begin
                    shift_en = 1'b1;
                    if (bit_idx == LAST_IDX) begin
                        state_nxt = TAIL;
                    end
                end
            end
            TAIL: begin
                if (cs_rise) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A strobe on the snapshot cycle lands after the snapshot: frame uses old shadow, fresh re-set
    always_ff @(posedge clk) begin
        if (rst) begin
            quat_sh <= '0;
            gyro_sh <= '0;
            qfresh  <= '0;
            gfresh  <= '0;
            done    <= 1'b0;
            overrun <= 1'b0;
            seq     <= 8'd0;
        end else begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (quat_valid[i]) begin
                    quat_sh[64*i +: 64] <= quat_data[64*i +: 64];
                end
                if (gyro_valid[i]) begin
                    gyro_sh[48*i +: 48] <= gyro_data[48*i +: 48];
                end
            end
            qfresh  <= (snap ? '0 : qfresh) | quat_valid;
            gfresh  <= (snap ? '0 : gfresh) | gyro_valid;
            done    <= (done & ~snap) | (|quat_valid) | (|gyro_valid);
            overrun <= snap ? 1'b0
                            : (overrun | (|(quat_valid & qfresh)) | (|(gyro_valid & gfresh)));
            if (snap) begin
                seq <= seq + 8'd1;
            end
        end
    end

    always_comb begin
        flags      = '0;
        frame_next = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            flags[2*i]   = qfresh[i];
            flags[2*i+1] = gfresh[i];
        end
        frame_next[BODY_BITS-1 -: 8] = HEADER_BYTE;
        frame_next[BODY_BITS-9 -: 8] = seq;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            frame_next[BODY_BITS-17-SENS_BITS*i -: 64] = quat_sh[64*i +: 64];
            frame_next[BODY_BITS-81-SENS_BITS*i -: 48] = gyro_sh[48*i +: 48];
        end
        frame_next[7:0] = flags;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_sr <= '0;
            bit_idx  <= '0;
        end else if (snap) begin
            frame_sr <= frame_next;
            bit_idx  <= '0;
        end else if (shift_en) begin
            frame_sr <= {frame_sr[BODY_BITS-2:0], 1'b0};
            bit_idx  <= bit_idx + IDX_W'(1);
        end
    end

    assign in_body = (bit_idx < BODY_END);

    crc8_serial u_crc (
        .clk    (clk),
        .rst    (rst),
        .clr    (snap),
        .en     (shift_en & in_body),
        .bit_in (frame_sr[BODY_BITS-1]),
        .crc    (crc)
    );

    // CRC byte starts on a byte boundary, so bit_idx[2:0] is the bit position within it
    always_comb begin
        sdo = 1'b0;
        if (state == SHIFT) begin
            if (in_body) begin
                sdo = frame_sr[BODY_BITS-1];
            end else if (CRC_EN) begin
                sdo = crc[3'd7 - bit_idx[2:0]];
            end
        end
    end

endmodule

// File: tb/tb_mcu_spi_frame_tx.sv
// Bench for mcu_spi_frame_tx: byte-level frame model with CRC on/off instances sharing stimulus.
module tb_mcu_spi_frame_tx;

    localparam int NS   = 2;
    localparam int FBY  = 4 + 14 * NS;
    localparam int HALF = 6;
    localparam int MAXB = FBY + 2;

    logic clk = 1'b0;
    logic rst, sck, cs_n, sdi;
    logic sdo_a, sdo_b, done_a, done_b, ovr_a, ovr_b;
    logic [NS-1:0]    quat_valid, gyro_valid;
    logic [64*NS-1:0] quat_data;
    logic [48*NS-1:0] gyro_data;

    always #5 clk = ~clk;

    mcu_spi_frame_tx #(.NUM_SENSORS(NS), .CRC_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .sdi(sdi), .sdo(sdo_a),
        .done(done_a), .overrun(ovr_a), .quat_valid(quat_valid), .quat_data(quat_data),
        .gyro_valid(gyro_valid), .gyro_data(gyro_data));

    mcu_spi_frame_tx #(.NUM_SENSORS(NS), .CRC_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .sdi(sdi), .sdo(sdo_b),
        .done(done_b), .overrun(ovr_b), .quat_valid(quat_valid), .quat_data(quat_data),
        .gyro_valid(gyro_valid), .gyro_data(gyro_data));

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] m_q [NS][4];
    logic [15:0] m_g [NS][3];
    logic        m_qf [NS];
    logic        m_gf [NS];
    logic [7:0]  m_seq;
    logic        m_done, m_ovr;
    logic [7:0]  exp_frame [FBY];
    logic [7:0]  got_a [MAXB];
    logic [7:0]  got_b [MAXB];
    logic [7:0]  spec_bytes [8];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, " done"}, {7'b0, done_a}, {7'b0, m_done});
        check({tag, " overrun"}, {7'b0, ovr_a}, {7'b0, m_ovr});
        check({tag, " done_b"}, {7'b0, done_b}, {7'b0, m_done});
    endtask

    function automatic logic [7:0] crc8_ref(input int n);
        logic [7:0] c = 8'h00;
        for (int b = 0; b < n; b++) begin
            c = c ^ exp_frame[b];
            for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            for (int w = 0; w < 4; w++) m_q[i][w] = 16'h0;
            for (int k = 0; k < 3; k++) m_g[i][k] = 16'h0;
            m_qf[i] = 1'b0;
            m_gf[i] = 1'b0;
        end
        m_seq = 8'd0; m_done = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic model_snapshot();
        logic [7:0] fl = 8'h00;
        exp_frame[0] = 8'hAA;
        exp_frame[1] = m_seq;
        for (int i = 0; i < NS; i++) begin
            for (int w = 0; w < 4; w++) begin
                exp_frame[2 + 14*i + 2*w]     = m_q[i][w][15:8];
                exp_frame[2 + 14*i + 2*w + 1] = m_q[i][w][7:0];
            end
            for (int k = 0; k < 3; k++) begin
                exp_frame[10 + 14*i + 2*k]     = m_g[i][k][15:8];
                exp_frame[10 + 14*i + 2*k + 1] = m_g[i][k][7:0];
            end
            if (m_qf[i]) fl = fl + 8'(1 << (2*i));
            if (m_gf[i]) fl = fl + 8'(1 << (2*i + 1));
            m_qf[i] = 1'b0;
            m_gf[i] = 1'b0;
        end
        exp_frame[FBY-2] = fl;
        exp_frame[FBY-1] = crc8_ref(FBY - 1);
        m_done = 1'b0;
        m_ovr  = 1'b0;
        m_seq  = m_seq + 8'd1;
    endtask

    // Called at a negedge; strobes are high for exactly one clock
    task automatic drive_strobe(input logic [NS-1:0] qv, input logic [NS-1:0] gv,
                                input logic [64*NS-1:0] qd, input logic [48*NS-1:0] gd);
        quat_valid = qv; gyro_valid = gv; quat_data = qd; gyro_data = gd;
        for (int i = 0; i < NS; i++) begin
            if (qv[i]) begin
                if (m_qf[i]) m_ovr = 1'b1;
                for (int w = 0; w < 4; w++) m_q[i][w] = qd[64*i + 48 - 16*w +: 16];
                m_qf[i] = 1'b1; m_done = 1'b1;
            end
            if (gv[i]) begin
                if (m_gf[i]) m_ovr = 1'b1;
                for (int k = 0; k < 3; k++) m_g[i][k] = gd[48*i + 32 - 16*k +: 16];
                m_gf[i] = 1'b1; m_done = 1'b1;
            end
        end
        @(negedge clk);
        quat_valid = '0; gyro_valid = '0;
        @(negedge clk);
    endtask

    task automatic random_strobe(input logic [NS-1:0] qv, input logic [NS-1:0] gv);
        logic [64*NS-1:0] qd;
        logic [48*NS-1:0] gd;
        for (int j = 0; j < 2*NS; j++) qd[32*j +: 32] = $urandom;
        for (int j = 0; j < 3*NS; j++) gd[16*j +: 16] = 16'($urandom);
        drive_strobe(qv, gv, qd, gd);
    endtask

    task automatic begin_frame();
        for (int b = 0; b < MAXB; b++) begin got_a[b] = 8'hxx; got_b[b] = 8'hxx; end
        cs_n = 1'b0;
        model_snapshot();
    endtask

    task automatic clock_bits(input int n);
        for (int k = 0; k < n; k++) begin
            repeat (HALF) @(negedge clk);
            got_a[k/8][7 - (k%8)] = sdo_a;
            got_b[k/8][7 - (k%8)] = sdo_b;
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
        repeat (HALF) @(negedge clk);
    endtask

    task automatic end_frame();
        cs_n = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input int nbytes);
        logic [7:0] ea, eb;
        for (int b = 0; b < nbytes; b++) begin
            ea = (b < FBY) ? exp_frame[b] : 8'h00;
            eb = (b == FBY - 1) ? 8'h00 : ea;
            check($sformatf("%s byte%0d crc_on", tag, b), got_a[b], ea);
            check($sformatf("%s byte%0d crc_off", tag, b), got_b[b], eb);
        end
    endtask

    task automatic full_frame(input string tag, input int nbytes);
        begin_frame();
        clock_bits(8 * nbytes);
        end_frame();
        check_frame(tag, nbytes);
    endtask

    initial begin
        logic [64*NS-1:0] qd;
        logic [48*NS-1:0] gd;
        rst = 1'b1; sck = 1'b0; cs_n = 1'b1; sdi = 1'b0;
        quat_valid = '0; gyro_valid = '0; quat_data = '0; gyro_data = '0;
        model_reset();
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset sdo", {7'b0, sdo_a}, 8'h00);
        check("reset sdo_b", {7'b0, sdo_b}, 8'h00);
        check_status("reset");

        full_frame("empty", FBY + 1);
        check("empty crc", got_a[FBY-1], crc8_ref(FBY - 1));
        check_status("empty");

        qd = '0; gd = '0;
        qd[63:0]  = {16'd1000, 16'hFFFF, 16'd2, 16'd3};
        gd[95:48] = {16'd5, 16'd6, 16'd7};
        drive_strobe(2'b01, 2'b00, qd, '0);
        drive_strobe(2'b00, 2'b10, '0, gd);
        check_status("directed strobe");
        full_frame("directed", FBY);
        spec_bytes = '{8'h03, 8'hE8, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h00, 8'h03};
        for (int b = 0; b < 8; b++) check($sformatf("quat0 byte%0d", b + 2), got_a[b + 2], spec_bytes[b]);
        check("directed flags", got_a[FBY-2], 8'h09);
        check("directed gyro1 gz lsb", got_a[FBY-3], 8'h07);
        check_status("after directed");
        full_frame("directed repeat", FBY);
        check("repeat flags", got_a[FBY-2], 8'h00);

        random_strobe(2'b01, 2'b00);
        random_strobe(2'b01, 2'b00);
        check_status("double strobe");
        begin_frame();
        repeat (HALF) @(negedge clk);
        check_status("overrun cleared");
        clock_bits(8 * FBY);
        end_frame();
        check_frame("overrun", FBY);

        random_strobe(2'b10, 2'b01);
        begin_frame();
        clock_bits(13);
        end_frame();
        check("abort sdo", {7'b0, sdo_a}, 8'h00);
        check("abort sdo_b", {7'b0, sdo_b}, 8'h00);
        check("abort byte0", got_a[0], exp_frame[0]);
        check("abort byte1 msbs", {got_a[1][7:3], 3'b000}, {exp_frame[1][7:3], 3'b000});
        full_frame("after abort", FBY);
        check("after abort flags", got_a[FBY-2], 8'h00);

        for (int t = 0; t < 5; t++) begin
            sck = 1'b1; repeat (HALF) @(negedge clk);
            sck = 1'b0; repeat (HALF) @(negedge clk);
        end
        check("idle sck sdo", {7'b0, sdo_a}, 8'h00);

        random_strobe(2'b01, 2'b00);
        cs_n = 1'b0;
        for (int b = 0; b < MAXB; b++) begin got_a[b] = 8'hxx; got_b[b] = 8'hxx; end
        model_snapshot();
        @(negedge clk);
        @(negedge clk);
        random_strobe(2'b10, 2'b10);
        clock_bits(8 * FBY);
        end_frame();
        check_frame("coincident", FBY);
        check_status("coincident");
        full_frame("post coincident", FBY);
        check("post coincident flags", got_a[FBY-2], 8'h0C);

        for (int r = 0; r < 3; r++) begin
            random_strobe(NS'($urandom_range(0, 3)), NS'($urandom_range(0, 3)));
            random_strobe(NS'($urandom_range(0, 3)), NS'($urandom_range(0, 3)));
            check_status($sformatf("random%0d", r));
            full_frame($sformatf("random%0d", r), (r == 0) ? FBY + 1 : FBY);
        end

        while (m_seq != 8'd255) begin
            cs_n = 1'b0;
            model_snapshot();
            repeat (HALF) @(negedge clk);
            end_frame();
        end
        random_strobe(2'b11, 2'b00);
        full_frame("seq 255", FBY);
        check("seq 255 byte", got_a[1], 8'hFF);
        full_frame("seq wrap", FBY);
        check("seq wrap byte", got_a[1], 8'h00);

        random_strobe(2'b01, 2'b11);
        begin_frame();
        clock_bits(20);
        rst = 1'b1;
        cs_n = 1'b1;
        @(negedge clk);
        check("rst sdo", {7'b0, sdo_a}, 8'h00);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_status("after rst");
        full_frame("after rst", FBY);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
